// File: rtl/reg_wport_arbiter_if.sv
// Bus bundle between the register-file write-port arbiter and the WB stage,
// the multi-cycle unit, the decode-stage hazard check and the register file.
interface reg_wport_arbiter_if;
  logic        wb_we;
  logic [4:0]  wb_wn;
  logic [31:0] wb_wd;
  logic        md_req;
  logic [4:0]  md_wn;
  logic [31:0] md_wd;
  logic        md_ack;
  logic        md_issue;
  logic [4:0]  md_issue_wn;
  logic [4:0]  RN1;
  logic [4:0]  RN2;
  logic        hz1;
  logic        hz2;
  logic        RegWrite;
  logic [4:0]  WN;
  logic [31:0] WD;
  logic        init_busy;
  logic        wb_stall;

  modport master (
    output wb_we, wb_wn, wb_wd, md_req, md_wn, md_wd,
           md_issue, md_issue_wn, RN1, RN2,
    input  md_ack, hz1, hz2, RegWrite, WN, WD, init_busy, wb_stall
  );

  modport slave (
    input  wb_we, wb_wn, wb_wd, md_req, md_wn, md_wd,
           md_issue, md_issue_wn, RN1, RN2,
    output md_ack, hz1, hz2, RegWrite, WN, WD, init_busy, wb_stall
  );
endinterface

// File: rtl/reg_wport_arbiter.sv
// Register-file write-port arbiter: zero-fill after reset, then WB/md arbitration
// with starvation protection. Define REGARB_SCOREBOARD_EN for the md hazard scoreboard.
module reg_wport_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input logic               clk,
  input logic               rst,
  reg_wport_arbiter_if.slave bus
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [4:0]  fill_cnt_r;
  logic [2:0]  starve_cnt_r;
  logic        starve_r;

  logic        wb_valid_s;
  logic        grant_wb_s;
  logic        grant_md_s;
  logic        md_lose_s;
  logic        starve_hit_s;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= INIT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: fill runs WN=1..31, then arbitration forever
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      INIT: begin
        if (fill_cnt_r == 5'd31) begin
          state_next_s = RUN;
        end else begin
          state_next_s = INIT;
        end
      end
      RUN:     state_next_s = RUN;
      default: state_next_s = INIT;
    endcase
  end

  // Grant decision; a starved md request pre-empts WB for one cycle
  always_comb begin
    wb_valid_s   = bus.wb_we && (bus.wb_wn != 5'd0);
    grant_md_s   = 1'b0;
    grant_wb_s   = 1'b0;
    if (state_r == RUN) begin
      grant_md_s = bus.md_req && (starve_r || !wb_valid_s);
      grant_wb_s = wb_valid_s && !starve_r;
    end else begin
      grant_md_s = 1'b0;
      grant_wb_s = 1'b0;
    end
    md_lose_s    = bus.md_req && grant_wb_s;
    starve_hit_s = (starve_cnt_r == 3'(MAX_WAIT - 1));
  end

  // Output logic
  always_comb begin
    bus.RegWrite  = 1'b0;
    bus.WN        = 5'd0;
    bus.WD        = 32'd0;
    bus.md_ack    = 1'b0;
    bus.init_busy = 1'b0;
    bus.wb_stall  = 1'b0;
    case (state_r)
      RUN: begin
        bus.wb_stall = starve_r;
        if (grant_md_s) begin
          // md to register 0 is acknowledged without touching the file
          bus.md_ack   = 1'b1;
          bus.RegWrite = (bus.md_wn != 5'd0);
          bus.WN       = bus.md_wn;
          bus.WD       = (bus.md_wn != 5'd0) ? bus.md_wd : 32'd0;
        end else if (grant_wb_s) begin
          bus.RegWrite = 1'b1;
          bus.WN       = bus.wb_wn;
          bus.WD       = bus.wb_wd;
        end else begin
          bus.RegWrite = 1'b0;
        end
      end
      default: begin
        bus.RegWrite  = 1'b1;
        bus.WN        = fill_cnt_r;
        bus.WD        = 32'd0;
        bus.init_busy = 1'b1;
        bus.wb_stall  = 1'b1;
      end
    endcase
  end

  // Zero-fill register index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt_r <= 5'd1;
    end else if ((state_r == INIT) && (fill_cnt_r != 5'd31)) begin
      fill_cnt_r <= fill_cnt_r + 5'd1;
    end else begin
      fill_cnt_r <= 5'd1;
    end
  end

  // Starvation counter and forced-grant flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_r <= 3'd0;
      starve_r     <= 1'b0;
    end else if (grant_md_s || !bus.md_req || (state_r != RUN)) begin
      starve_cnt_r <= 3'd0;
      starve_r     <= 1'b0;
    end else if (md_lose_s) begin
      starve_cnt_r <= starve_cnt_r + 3'd1;
      starve_r     <= starve_hit_s;
    end else begin
      starve_cnt_r <= starve_cnt_r;
      starve_r     <= starve_r;
    end
  end

`ifdef REGARB_SCOREBOARD_EN
  logic [31:1] busy_r;
  logic [31:0] busy_set_s;
  logic [31:0] busy_clr_s;
  logic [31:0] busy_full_s;

  // Busy set/clear masks; register 0 never becomes busy
  always_comb begin
    busy_set_s = 32'd0;
    busy_clr_s = 32'd0;
    if (bus.md_issue && (bus.md_issue_wn != 5'd0)) begin
      busy_set_s[bus.md_issue_wn] = 1'b1;
    end else begin
      busy_set_s = 32'd0;
    end
    if (grant_md_s) begin
      busy_clr_s[bus.md_wn] = 1'b1;
    end else begin
      busy_clr_s = 32'd0;
    end
    busy_full_s = {busy_r, 1'b0};
    bus.hz1     = busy_full_s[bus.RN1];
    bus.hz2     = busy_full_s[bus.RN2];
  end

  // Busy bits: set wins over a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 31'd0;
    end else begin
      busy_r <= (busy_r & ~busy_clr_s[31:1]) | busy_set_s[31:1];
    end
  end
`else
  logic unused_sb_s;

  assign unused_sb_s = ^{bus.md_issue, bus.md_issue_wn, bus.RN1, bus.RN2};

  // Scoreboard absent: no hazards ever reported
  always_comb begin
    bus.hz1 = 1'b0;
    bus.hz2 = 1'b0;
  end
`endif

endmodule

// File: tb/tb_reg_wport_arbiter.sv
// Directed self-checking bench for reg_wport_arbiter; expected per-cycle
// outputs are queued as stimulus is applied and compared when sampled.
module tb_reg_wport_arbiter;

`ifdef REGARB_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    string       tag;
    logic [42:0] val;
  } exp_t;

  exp_t exp_q[$];

  reg_wport_arbiter_if bus ();

  reg_wport_arbiter #(.MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector: {RegWrite, WN, WD, md_ack, wb_stall, init_busy, hz1, hz2}
  function automatic logic [42:0] ex(input logic rw, input logic [4:0] wn, input logic [31:0] wd,
                                     input logic ack, input logic stall, input logic init,
                                     input logic h1, input logic h2);
    return {rw, wn, wd, ack, stall, init, h1, h2};
  endfunction

  task automatic push(input string tag, input logic [42:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  // Sample a few ns after the inputs settle, compare, then move to the next negedge
  task automatic cyc(input string tag, input logic [42:0] v);
    exp_t e;
    logic [42:0] obs;
    push(tag, v);
    #2;
    obs = {bus.RegWrite, bus.WN, bus.WD, bus.md_ack, bus.wb_stall, bus.init_busy, bus.hz1, bus.hz2};
    e = exp_q.pop_front();
    checks++;
    assert (obs === e.val) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (RegWrite,WN,WD,md_ack,wb_stall,init_busy,hz1,hz2)",
             e.tag, obs, e.val);
    end
    @(negedge clk);
  endtask

  task automatic drive_wb(input logic we, input logic [4:0] wn, input logic [31:0] wd);
    bus.wb_we = we;
    bus.wb_wn = wn;
    bus.wb_wd = wd;
  endtask

  task automatic drive_md(input logic req, input logic [4:0] wn, input logic [31:0] wd);
    bus.md_req = req;
    bus.md_wn  = wn;
    bus.md_wd  = wd;
  endtask

  initial begin
    rst = 1'b0;
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_md(1'b0, 5'd0, 32'd0);
    bus.md_issue    = 1'b0;
    bus.md_issue_wn = 5'd0;
    bus.RN1         = 5'd0;
    bus.RN2         = 5'd0;
    #1 rst = 1'b1;
    @(negedge clk);
    cyc("reset", ex(1'b1, 5'd1, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    rst = 1'b0;

    // Zero-fill with WB traffic present, which must be ignored
    drive_wb(1'b1, 5'd3, 32'hDEAD_BEEF);
    for (int i = 1; i <= 31; i++) begin
      cyc($sformatf("fill%0d", i), ex(1'b1, 5'(i), 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    end
    drive_wb(1'b0, 5'd0, 32'd0);
    cyc("first_run_idle", ex(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Priority conflict
    drive_wb(1'b1, 5'd5, 32'h11);
    drive_md(1'b1, 5'd7, 32'h22);
    cyc("prio_wb", ex(1'b1, 5'd5, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    drive_wb(1'b0, 5'd0, 32'd0);
    cyc("prio_md", ex(1'b1, 5'd7, 32'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    drive_md(1'b0, 5'd0, 32'd0);

    // Starvation, twice in a row to show the counter restarts after the ack
    for (int r = 0; r < 2; r++) begin
      drive_md(1'b1, 5'd20, 32'hABCD);
      for (int k = 0; k < 4; k++) begin
        drive_wb(1'b1, 5'(6 + k), 32'(100 + k));
        cyc($sformatf("starve_r%0d_lose%0d", r, k),
            ex(1'b1, 5'(6 + k), 32'(100 + k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      drive_wb(1'b1, 5'd10, 32'd104);
      cyc($sformatf("starve_r%0d_force", r), ex(1'b1, 5'd20, 32'hABCD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
      drive_md(1'b0, 5'd0, 32'd0);
      cyc($sformatf("starve_r%0d_resume", r), ex(1'b1, 5'd10, 32'd104, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    end

    // Register 0 handling
    drive_wb(1'b1, 5'd0, 32'h55);
    drive_md(1'b1, 5'd9, 32'h99);
    cyc("wb_r0_md_wins", ex(1'b1, 5'd9, 32'h99, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_md(1'b1, 5'd0, 32'h77);
    cyc("md_r0_ack", ex(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    drive_md(1'b0, 5'd0, 32'd0);
    drive_wb(1'b1, 5'd0, 32'h66);
    cyc("wb_r0_noop", ex(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    drive_wb(1'b0, 5'd0, 32'd0);

    // Scoreboard (hazards stay 0 when it is compiled out)
    bus.md_issue = 1'b1; bus.md_issue_wn = 5'd12; bus.RN1 = 5'd12; bus.RN2 = 5'd13;
    cyc("sb_issue", ex(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    bus.md_issue = 1'b0;
    cyc("sb_busy_rn1", ex(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, SB, 1'b0));
    bus.RN2 = 5'd12;
    cyc("sb_busy_both", ex(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, SB, SB));
    drive_md(1'b1, 5'd12, 32'h12);
    cyc("sb_ack_cycle", ex(1'b1, 5'd12, 32'h12, 1'b1, 1'b0, 1'b0, SB, SB));
    drive_md(1'b0, 5'd0, 32'd0);
    cyc("sb_cleared", ex(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    bus.md_issue = 1'b1;
    cyc("sb_reissue", ex(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    drive_md(1'b1, 5'd12, 32'h34);
    cyc("sb_set_clr_same", ex(1'b1, 5'd12, 32'h34, 1'b1, 1'b0, 1'b0, SB, SB));
    drive_md(1'b0, 5'd0, 32'd0);
    bus.md_issue = 1'b0;
    cyc("sb_set_wins", ex(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, SB, SB));
    bus.md_issue = 1'b1; bus.md_issue_wn = 5'd0; bus.RN1 = 5'd0;
    cyc("sb_r0_issue", ex(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, SB));
    bus.md_issue = 1'b0;
    cyc("sb_r0_never_busy", ex(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, SB));

    // Async reset in RUN with an md request pending behind WB traffic
    bus.RN1 = 5'd12; bus.RN2 = 5'd0;
    drive_wb(1'b1, 5'd4, 32'h44);
    drive_md(1'b1, 5'd15, 32'hF0F0);
    cyc("pre_reset_wb", ex(1'b1, 5'd4, 32'h44, 1'b0, 1'b0, 1'b0, SB, 1'b0));
    #2 rst = 1'b1;
    cyc("async_reset", ex(1'b1, 5'd1, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    rst = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      cyc($sformatf("refill%0d", i), ex(1'b1, 5'(i), 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    end
    cyc("post_reset_wb", ex(1'b1, 5'd4, 32'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    drive_wb(1'b0, 5'd0, 32'd0);
    cyc("post_reset_md", ex(1'b1, 5'd15, 32'hF0F0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    drive_md(1'b0, 5'd0, 32'd0);
    cyc("final_idle", ex(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
